// File: rtl/wbuffer_pkg.sv
// Shared types for the store write buffer: entry layout, drain FSM states and
// the default queue depth.
package wbuffer_pkg;

  localparam int WBUF_DEPTH = 8;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strobe;
  } wbuf_entry_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } wbuf_state_t;

  function automatic logic [63:0] align_addr(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/wbuffer_lookup.sv
// One store-to-load forwarding port: per byte lane, the youngest valid entry
// with a matching aligned address and a set strobe bit supplies the byte.
module wbuffer_lookup
  import wbuffer_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  wbuf_entry_t       entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     head,
  input  logic [PW:0]       count,
  input  logic              req_valid,
  input  logic [63:0]       req_addr,
  output logic [63:0]       data,
  output logic [7:0]        hit
);

  logic [PW-1:0] idx [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_idx
      assign idx[gi] = head + PW'(gi);
    end
  endgenerate

  // Walk oldest to youngest so that younger entries overwrite older bytes.
  always_comb begin
    data = '0;
    hit  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (req_valid && valid[idx[k]] && ((PW+1)'(k) < count) &&
          (entries[idx[k]].addr == align_addr(req_addr))) begin
        for (int b = 0; b < 8; b++) begin
          if (entries[idx[k]].strobe[b]) begin
            data[8*b +: 8] = entries[idx[k]].data[8*b +: 8];
            hit[b]         = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// In-order store write buffer with two forwarding ports and a two-state drain
// to the data bus. Define WBUFFER_MERGE_EN to coalesce stores into the youngest entry.
module write_buffer
  import wbuffer_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wreq_valid,
  input  logic [63:0]              wreq_addr,
  input  logic [63:0]              wreq_data,
  input  logic [7:0]               wreq_strobe,
  output logic                     wreq_ready,
  input  logic [1:0]               rreq_valid,
  input  logic [1:0][63:0]         rreq_addr,
  output logic [1:0][63:0]         rresp_data,
  output logic [1:0][7:0]          rresp_hit,
  output logic                     dbus_wvalid,
  output logic [63:0]              dbus_waddr,
  output logic [63:0]              dbus_wdata,
  output logic [7:0]               dbus_wstrobe,
  input  logic                     dbus_wready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  wbuf_entry_t   entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head_reg, tail_reg;
  logic [PW:0]   count_reg;
  wbuf_state_t   state_reg, state_next;
  wbuf_entry_t   out_reg;
  wbuf_entry_t   new_entry, head_entry;
  logic          full, pop, accept, alloc, mergeable;

  assign full      = (count_reg == (PW+1)'(DEPTH));
  assign pop       = (state_reg == ISSUE) && dbus_wready;
  assign new_entry = {align_addr(wreq_addr), wreq_data, wreq_strobe};
  assign accept    = wreq_valid && wreq_ready;
  assign alloc     = accept && !mergeable;

`ifdef WBUFFER_MERGE_EN
  logic [PW-1:0] young_idx;
  wbuf_entry_t   merged_entry;

  assign young_idx = tail_reg - PW'(1);

  always_comb begin
    merged_entry = entries[young_idx];
    for (int b = 0; b < 8; b++) begin
      if (wreq_strobe[b]) merged_entry.data[8*b +: 8] = wreq_data[8*b +: 8];
    end
    merged_entry.strobe = entries[young_idx].strobe | wreq_strobe;
  end

  // An entry already captured for the bus must not change underneath it.
  assign mergeable  = (count_reg != '0) && (entries[young_idx].addr == new_entry.addr) &&
                      !((state_reg == ISSUE) && (young_idx == head_reg));
  assign wreq_ready = !full || mergeable;
  // A merge into the head while IDLE lands in the same edge as the capture.
  assign head_entry = (accept && mergeable && (young_idx == head_reg)) ? merged_entry
                                                                       : entries[head_reg];
`else
  assign mergeable  = 1'b0;
  assign wreq_ready = !full;
  assign head_entry = entries[head_reg];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      if (alloc) entries[tail_reg] <= new_entry;
`ifdef WBUFFER_MERGE_EN
      else if (accept) entries[young_idx] <= merged_entry;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= IDLE;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (alloc) tail_reg <= tail_reg + PW'(1);
      if (pop)   head_reg <= head_reg + PW'(1);
      if (alloc && !pop)      count_reg <= count_reg + (PW+1)'(1);
      else if (pop && !alloc) count_reg <= count_reg - (PW+1)'(1);
      if ((state_reg == IDLE) && (count_reg != '0)) out_reg <= head_entry;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = ISSUE;
      ISSUE:   if (dbus_wready)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PW-1:0] age;
      assign age       = PW'(gi) - head_reg;
      assign valid[gi] = ({1'b0, age} < count_reg);
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      wbuffer_lookup #(.DEPTH(DEPTH)) u_lookup (
        .entries   (entries),
        .valid     (valid),
        .head      (head_reg),
        .count     (count_reg),
        .req_valid (rreq_valid[gi]),
        .req_addr  (rreq_addr[gi]),
        .data      (rresp_data[gi]),
        .hit       (rresp_hit[gi])
      );
    end
  endgenerate

  assign dbus_wvalid  = (state_reg == ISSUE);
  assign dbus_waddr   = out_reg.addr;
  assign dbus_wdata   = out_reg.data;
  assign dbus_wstrobe = out_reg.strobe;
  assign empty        = (count_reg == '0);
  assign count        = count_reg;

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: drain scoreboard, forwarding lookups,
// full/wrap behaviour, reset mid-transaction and (with WBUFFER_MERGE_EN) merging.
module tb_write_buffer;
  import wbuffer_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wreq_valid = 1'b0;
  logic [63:0]     wreq_addr = '0;
  logic [63:0]     wreq_data = '0;
  logic [7:0]      wreq_strobe = '0;
  logic            wreq_ready;
  logic [1:0]      rreq_valid = '0;
  logic [1:0][63:0] rreq_addr = '0;
  logic [1:0][63:0] rresp_data;
  logic [1:0][7:0] rresp_hit;
  logic            dbus_wvalid;
  logic [63:0]     dbus_waddr;
  logic [63:0]     dbus_wdata;
  logic [7:0]      dbus_wstrobe;
  logic            dbus_wready = 1'b0;
  logic            empty;
  logic [3:0]      count;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .wreq_valid(wreq_valid), .wreq_addr(wreq_addr), .wreq_data(wreq_data),
    .wreq_strobe(wreq_strobe), .wreq_ready(wreq_ready),
    .rreq_valid(rreq_valid), .rreq_addr(rreq_addr),
    .rresp_data(rresp_data), .rresp_hit(rresp_hit),
    .dbus_wvalid(dbus_wvalid), .dbus_waddr(dbus_waddr), .dbus_wdata(dbus_wdata),
    .dbus_wstrobe(dbus_wstrobe), .dbus_wready(dbus_wready),
    .empty(empty), .count(count)
  );

  wbuf_entry_t sb[$];
  wbuf_entry_t mon_exp;
  int  n_cmp = 0;
  int  n_err = 0;
  bit  sb_en = 1'b1;

  // Drain monitor: every bus handshake must match the oldest outstanding store.
  always @(negedge clk) begin
    if (reset && sb_en && dbus_wvalid && dbus_wready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL drain_unexpected: got addr=%h data=%h strobe=%h, required no drain",
                 dbus_waddr, dbus_wdata, dbus_wstrobe);
      end else begin
        mon_exp = sb.pop_front();
        if ({dbus_waddr, dbus_wdata, dbus_wstrobe} !== mon_exp) begin
          n_err++;
          $display("FAIL drain_entry: got %h/%h/%h, required %h/%h/%h",
                   dbus_waddr, dbus_wdata, dbus_wstrobe,
                   mon_exp.addr, mon_exp.data, mon_exp.strobe);
        end else begin
          $display("drain addr=%h data=%h strobe=%h ok", dbus_waddr, dbus_wdata, dbus_wstrobe);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    wbuf_entry_t e;
    wreq_valid = 1'b1; wreq_addr = a; wreq_data = d; wreq_strobe = s;
    #1;
    if (wreq_ready) begin
      e.addr = {a[63:3], 3'b000}; e.data = d; e.strobe = s;
      sb.push_back(e);
    end
    $display("store addr=%h data=%h strobe=%h ready=%0d", a, d, s, wreq_ready);
    @(posedge clk);
    #1;
    wreq_valid = 1'b0;
  endtask

  task automatic drain_all();
    bit done = 1'b0;
    dbus_wready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      done = empty && !dbus_wvalid;
    end
    dbus_wready = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL drain_timeout: got count=%0d, required 0 within 200 cycles", count);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL drain_leftover: got %0d undrained, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rreq_valid = 2'b11; rreq_addr[0] = 64'h1000; rreq_addr[1] = 64'h0;
    step(); step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({dbus_wvalid, empty, wreq_ready, count} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
      n_err++; $display("FAIL reset_flags: got wvalid=%b empty=%b ready=%b count=%0d, required 0 1 1 0",
                        dbus_wvalid, empty, wreq_ready, count);
    end
    n_cmp++;
    if ({dbus_waddr, dbus_wdata, dbus_wstrobe} !== 136'd0) begin
      n_err++; $display("FAIL reset_bus: got %h/%h/%h, required zeros", dbus_waddr, dbus_wdata, dbus_wstrobe);
    end
    n_cmp++;
    if (rresp_hit !== 16'h0) begin
      n_err++; $display("FAIL reset_hit: got %h, required 0000", rresp_hit);
    end
    rreq_valid = 2'b00;
  endtask

  task automatic test_basic();
    dbus_wready = 1'b0;
    store(64'h1000, 64'h1122334455667788, 8'hFF);
    n_cmp++;
    if ({count, dbus_wvalid} !== {4'd1, 1'b0}) begin
      n_err++; $display("FAIL basic_n1: got count=%0d wvalid=%b, required 1 0", count, dbus_wvalid);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({dbus_wvalid, dbus_waddr, dbus_wdata, dbus_wstrobe} !==
          {1'b1, 64'h1000, 64'h1122334455667788, 8'hFF}) begin
        n_err++; $display("FAIL basic_issue%0d: got %b/%h/%h/%h, required 1/1000/1122334455667788/ff",
                          i, dbus_wvalid, dbus_waddr, dbus_wdata, dbus_wstrobe);
      end
      if (i < 3) step();
    end
    dbus_wready = 1'b1;
    step();
    dbus_wready = 1'b0;
    n_cmp++;
    if ({empty, dbus_wvalid, sb.size() == 0} !== 3'b101) begin
      n_err++; $display("FAIL basic_done: got empty=%b wvalid=%b pending=%0d, required 1 0 0",
                        empty, dbus_wvalid, sb.size());
    end
  endtask

  task automatic test_fill();
    logic [63:0] dat [8];
    logic [63:0] d9;
    dbus_wready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dat[i] = {$urandom, $urandom};
      store(64'h8000 + 64'(i * 8), dat[i], 8'hFF);
    end
    n_cmp++;
    if ({count, wreq_ready} !== {4'd8, 1'b0}) begin
      n_err++; $display("FAIL fill_full: got count=%0d ready=%b, required 8 0", count, wreq_ready);
    end
    store(64'h9000, 64'hDEAD, 8'hFF);
    n_cmp++;
    if (count !== 4'd8) begin
      n_err++; $display("FAIL fill_reject: got count=%0d, required 8", count);
    end
    rreq_valid = 2'b01; rreq_addr[0] = 64'h803B; #1;
    n_cmp++;
    if ({rresp_hit[0], rresp_data[0]} !== {8'hFF, dat[7]}) begin
      n_err++; $display("FAIL fill_fwd: got hit=%h data=%h, required ff %h", rresp_hit[0], rresp_data[0], dat[7]);
    end
    dbus_wready = 1'b1;
    step();
    dbus_wready = 1'b0;
    n_cmp++;
    if ({count, wreq_ready} !== {4'd7, 1'b1}) begin
      n_err++; $display("FAIL fill_pop1: got count=%0d ready=%b, required 7 1", count, wreq_ready);
    end
    d9 = {$urandom, $urandom};
    store(64'hA000, d9, 8'hFF);
    n_cmp++;
    if (count !== 4'd8) begin
      n_err++; $display("FAIL fill_wrap_count: got %0d, required 8", count);
    end
    rreq_valid = 2'b11; rreq_addr[0] = 64'hA000; rreq_addr[1] = 64'h8000; #1;
    n_cmp++;
    if ({rresp_hit[0], rresp_data[0]} !== {8'hFF, d9}) begin
      n_err++; $display("FAIL fill_wrap_fwd: got hit=%h data=%h, required ff %h", rresp_hit[0], rresp_data[0], d9);
    end
    n_cmp++;
    if (rresp_hit[1] !== 8'h00) begin
      n_err++; $display("FAIL fill_popped_hit: got %h, required 00", rresp_hit[1]);
    end
    rreq_valid = 2'b00;
    drain_all();
  endtask

  task automatic test_forward();
    dbus_wready = 1'b0;
    store(64'h2000, 64'hAAAAAAAA, 8'h0F);
    step();
    store(64'h2000, 64'hBBBB, 8'h03);
    rreq_valid = 2'b11; rreq_addr[0] = 64'h2004; rreq_addr[1] = 64'h3000; #1;
    n_cmp++;
    if ({rresp_hit[0], rresp_data[0][31:0]} !== {8'h0F, 32'hAAAABBBB}) begin
      n_err++; $display("FAIL fwd_merge_bytes: got hit=%h data=%h, required 0f aaaabbbb",
                        rresp_hit[0], rresp_data[0][31:0]);
    end
    n_cmp++;
    if (rresp_hit[1] !== 8'h00) begin
      n_err++; $display("FAIL fwd_miss: got %h, required 00", rresp_hit[1]);
    end
    rreq_valid = 2'b10; rreq_addr[1] = 64'h2000; #1;
    n_cmp++;
    if ({rresp_hit[0], rresp_hit[1]} !== {8'h00, 8'h0F}) begin
      n_err++; $display("FAIL fwd_port_valid: got %h %h, required 00 0f", rresp_hit[0], rresp_hit[1]);
    end
    rreq_valid = 2'b00;
    drain_all();
  endtask

`ifdef WBUFFER_MERGE_EN
  task automatic test_merge();
    sb_en = 1'b0;
    dbus_wready = 1'b0;
    store(64'h4000, 64'h11111111, 8'h0F);
    store(64'h4000, 64'h2222222200000000, 8'hF0);
    n_cmp++;
    if ({count, dbus_wvalid, dbus_wstrobe, dbus_wdata} !== {4'd1, 1'b1, 8'hFF, 64'h2222222211111111}) begin
      n_err++; $display("FAIL merge_pair: got count=%0d wvalid=%b strobe=%h data=%h, required 1 1 ff 2222222211111111",
                        count, dbus_wvalid, dbus_wstrobe, dbus_wdata);
    end
    for (int k = 1; k < 8; k++) store(64'h5000 + 64'(k * 8), 64'(k), 8'hFF);
    #1;
    n_cmp++;
    if ({count, wreq_ready} !== {4'd8, 1'b1}) begin
      n_err++; $display("FAIL merge_full_ready: got count=%0d ready=%b, required 8 1", count, wreq_ready);
    end
    store(64'h5038, 64'hEE, 8'h01);
    wreq_addr = 64'h6000; #1;
    n_cmp++;
    if ({count, wreq_ready} !== {4'd8, 1'b0}) begin
      n_err++; $display("FAIL merge_full_accept: got count=%0d ready=%b, required 8 0", count, wreq_ready);
    end
    reset = 1'b0; step(); reset = 1'b1; step();
    sb.delete();
    sb_en = 1'b1;
  endtask
`endif

  task automatic test_reset_issue();
    dbus_wready = 1'b0;
    store(64'h7000, 64'h0123456789ABCDEF, 8'hFF);
    step();
    rreq_valid = 2'b11; rreq_addr[0] = 64'h7000; rreq_addr[1] = 64'h7007; #1;
    n_cmp++;
    if ({dbus_wvalid, rresp_hit[0]} !== {1'b1, 8'hFF}) begin
      n_err++; $display("FAIL rstissue_pre: got wvalid=%b hit=%h, required 1 ff", dbus_wvalid, rresp_hit[0]);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({dbus_wvalid, count, empty, rresp_hit} !== {1'b0, 4'd0, 1'b1, 16'h0}) begin
      n_err++; $display("FAIL rstissue_post: got wvalid=%b count=%0d empty=%b hit=%h, required 0 0 1 0000",
                        dbus_wvalid, count, empty, rresp_hit);
    end
    reset = 1'b1;
    sb.delete();
    step();
    n_cmp++;
    if (dbus_wvalid !== 1'b0) begin
      n_err++; $display("FAIL rstissue_idle: got wvalid=%b, required 0", dbus_wvalid);
    end
    rreq_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_forward();
`ifdef WBUFFER_MERGE_EN
    test_merge();
`endif
    test_reset_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
# write_buffer

Store write buffer at the far end of the execute stage's write-buffer interface. Accepts committed store writes from the memory unit, holds them in an in-order queue, and answers the memory unit's two load-forwarding lookups with per-byte hit masks. Drains the oldest entry to the data bus with a valid/ready handshake.

## Interface

- `DEPTH`, 8, number of entries; power of two, at least 2
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low (0 = reset)
- `wreq_valid`  in  1  store write request
- `wreq_addr`  in  64  byte address; bits [2:0] ignored and stored as zero
- `wreq_data`  in  64  store data, lane-aligned
- `wreq_strobe`  in  8  byte enables
- `wreq_ready`  out  1  write accepted when `wreq_valid & wreq_ready`
- `rreq_valid`  in  2  forwarding lookup valid, one bit per port
- `rreq_addr`  in  2x64  lookup address; bits [2:0] ignored
- `rresp_data`  out  2x64  forwarded bytes; don't-care where the hit bit is 0
- `rresp_hit`  out  2x8  per-byte hit mask; all zero when `rreq_valid[i]`=0
- `dbus_wvalid`  out  1  drain request to data bus
- `dbus_waddr`  out  64  aligned address of the draining entry
- `dbus_wdata`  out  64  data of the draining entry
- `dbus_wstrobe`  out  8  byte enables of the draining entry
- `dbus_wready`  in  1  bus accepts; handshake completes when `dbus_wvalid & dbus_wready`
- `empty`  out  1  no entries held (`count`=0)
- `count`  out  log2(DEPTH)+1  occupied entries

## Operation

- Circular queue with head/tail pointers of log2(DEPTH) bits (wrap modulo DEPTH) and a separate `count`.
- Enqueue: on handshake, write {aligned addr, data, strobe} at tail; tail++, count++.
- `wreq_ready` = (count < DEPTH), from registered count only. A pop in the same cycle does not free a slot for that cycle.
- Drain FSM, two states:
  - IDLE: if count>0, copy the head entry into the `dbus_w*` output registers and go to ISSUE.
  - ISSUE: `dbus_wvalid`=1 and outputs stay stable. On `dbus_wready`, pop the head (head++, count--) and go to IDLE.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- Forwarding, per port, combinational from registered state only. For each byte lane, search from youngest to oldest. The first valid entry with a matching aligned address and a set strobe bit supplies that byte and sets its hit bit.
- The in-flight head stays visible to forwarding until it is popped.
- A store accepted in cycle N is visible to lookups from cycle N+1.
- Reset: head=tail=0, count=0, FSM=IDLE, `dbus_wvalid`=0, `dbus_waddr/wdata/wstrobe`=0, `empty`=1, `wreq_ready`=1. Reset in ISSUE abandons the transaction; `dbus_wvalid` is 0 after the reset edge.

## Timing

- Enqueue into an empty, IDLE buffer in cycle N: `count`=1 in N+1; `dbus_wvalid`=1 in N+2.
- Accept in cycle M: `dbus_wvalid`=0 in M+1; the next entry is presented at M+2 at the earliest. Sustained drain rate is one entry per 2 cycles.
- `wreq_ready`, `empty` and `count` are functions of registers; there is no combinational path from `wreq_valid` or `dbus_wready`.
- The forwarding path is combinational from `rreq_addr` to `rresp_*` with zero latency.

## Configuration

- `WBUFFER_MERGE_EN` defined: an incoming store whose aligned address equals the youngest entry's address merges into that entry instead of allocating.
  - The merge condition requires count>0 and that the youngest entry is not the head while the FSM is in ISSUE.
  - Merging updates data where `wreq_strobe` is set and ORs the strobe; count is unchanged.
  - `wreq_ready` is also 1 when full if the request is mergeable; this is the only combinational path from `wreq_addr` to `wreq_ready`.
- Undefined: every accepted store allocates a new entry.

## Structure

- `wbuffer_pkg`: `wbuf_entry_t` {addr 64, data 64, strobe 8}, `wbuf_state_t` {IDLE, ISSUE}, default `WBUF_DEPTH`=8.
- Sub-module `wbuffer_lookup`: one forwarding port. Inputs are the entry array, valid vector, head and count; outputs are data and hit. Instantiated twice.

## Test plan

- Reset, then a store to addr 0x1000, data 0x1122334455667788, strobe 0xFF → `dbus_wvalid` high 2 cycles later with the same addr, data and strobe; hold `dbus_wready` low 3 cycles → outputs stable; ready high → `empty`=1 the next cycle.
- Fill 8 entries with `dbus_wready`=0 → `wreq_ready`=0 and `count`=8; assert ready for 1 cycle → drains the head only; 9th store accepted the following cycle; pointers wrap.
- Stores to 0x2000 strobe 0x0F (data 0xAAAAAAAA) then strobe 0x03 (data 0xBBBB) → lookup at 0x2004 returns hit 0x0F, bytes 1:0 = 0xBB, bytes 3:2 = 0xAA.
- Same-cycle lookups on both ports, at 0x2000 (hit) and 0x3000 (miss) → port 0 hit nonzero, port 1 hit 0x00.
- With `WBUFFER_MERGE_EN` set: two back-to-back stores to 0x4000 while the buffer is not draining → `count`=1, merged strobe; full buffer plus a mergeable store → accepted.
- Reset asserted while in ISSUE → `dbus_wvalid`=0, `count`=0, and lookups report no hits on the next cycle.
